bitty_instr_feeder: RTL and testbench

Instruction source for the Bitty processor core: the driving end of the core's `din`/`done` interface. A host preloads a small program memory. On `start`, the block presents one 16-bit instruction at a time on `dout` and holds it stable. It advances to the next instruction only after the core signals completion on `done`, stops after a programmed count, and flags a hung core with a timeout.

---
 rtl/bitty_instr_feeder.sv | 165 ++++++++++++++++
 tb/tb_bitty_instr_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_instr_feeder.sv
// Instruction feeder for the Bitty core: presents one instruction at a time
// from a host-loaded program memory, advances on each rising edge of the
// core's done, stops after a programmed count and flags a hung core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; dout/pc hold, loads allowed
// S_FETCH | memory read of mem[pc] into dout, timeout counter cleared
// S_WAIT  | dout valid, waiting for a done rising edge or timeout
// S_ERROR | core never answered; dout/pc hold, loads allowed, restartable
module bitty_instr_feeder #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_en,
    input  logic [AW-1:0] i_load_addr,
    input  logic [15:0]   i_load_data,
    input  logic          i_start,
    input  logic [AW-1:0] i_count,
    input  logic          i_done,
    output logic [15:0]   o_dout,
    output logic          o_instr_valid,
    output logic [AW-1:0] o_pc,
    output logic          o_busy,
    output logic          o_finished,
    output logic          o_timeout_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_mem [DEPTH];
    logic [15:0]   r_dout;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_count;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_done_q;
    logic          r_finished;
    logic          r_timeout_err;

    logic          w_busy;
    logic          w_done_rise;
    logic          w_accept_start;
    logic          w_pc_inc;
    logic          w_finish;
    logic          w_tmo_hit;
    logic          w_mem_we;
    logic [15:0]   w_rd_data;

    assign w_busy      = (r_state == S_FETCH) || (r_state == S_WAIT);
    assign w_done_rise = i_done & ~r_done_q;

    // Host writes only land while the sequencer is not running.
    assign w_mem_we  = i_load_en && !w_busy && (int'(i_load_addr) < DEPTH);
    assign w_rd_data = (int'(r_pc) < DEPTH) ? r_mem[r_pc] : 16'h0000;

    // Program memory: no reset so contents survive a mid-run reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[i_load_addr] <= i_load_data;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept_start = 1'b0;
        w_pc_inc       = 1'b0;
        w_finish       = 1'b0;
        w_tmo_hit      = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (i_start && (i_count != '0)) begin
                    w_accept_start = 1'b1;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_rise) begin
                    if (r_pc == (r_count - AW'(1))) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pc_inc    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = S_ERROR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: instruction, pc, count, timeout and status flags.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dout        <= '0;
            r_pc          <= '0;
            r_count       <= '0;
            r_tmo_cnt     <= '0;
            r_done_q      <= 1'b0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_q   <= i_done;
            r_finished <= w_finish;

            if (w_accept_start) begin
                r_count       <= i_count;
                r_pc          <= '0;
                r_timeout_err <= 1'b0;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + AW'(1);
            end

            if (w_tmo_hit) begin
                r_timeout_err <= 1'b1;
            end

            if (r_state == S_FETCH) begin
                r_dout    <= w_rd_data;
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT) && !w_done_rise && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

    assign o_dout        = r_dout;
    assign o_pc          = r_pc;
    assign o_busy        = w_busy;
    assign o_instr_valid = (r_state == S_WAIT);
    assign o_finished    = r_finished;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bitty_instr_feeder.sv
// Bench for bitty_instr_feeder: a simple memory image plus the expected
// instruction sequence drive randomized done timing and check each step.
module tb_bitty_instr_feeder;

    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int TIMEOUT = 64;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_load_en = 1'b0;
    logic [AW-1:0] i_load_addr = '0;
    logic [15:0]   i_load_data = '0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_count = '0;
    logic          i_done = 1'b0;
    logic [15:0]   o_dout;
    logic          o_instr_valid;
    logic [AW-1:0] o_pc;
    logic          o_busy;
    logic          o_finished;
    logic          o_timeout_err;

    logic [15:0]   m_mem [DEPTH];
    int            n_cmp = 0;
    int            n_err = 0;

    bitty_instr_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_load_en(i_load_en),
        .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .i_start(i_start), .i_count(i_count), .i_done(i_done),
        .o_dout(o_dout), .o_instr_valid(o_instr_valid), .o_pc(o_pc),
        .o_busy(o_busy), .o_finished(o_finished), .o_timeout_err(o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        logic [AW-1:0] av;
        av = a[AW-1:0];
        i_load_en = 1'b1; i_load_addr = av; i_load_data = d;
        tick();
        i_load_en = 1'b0;
        m_mem[a] = d;
    endtask

    // Run one program of cnt instructions; done held for hold_min..hold_max cycles.
    task automatic run_prog(input int cnt, input int hold_min, input int hold_max, input bit poke);
        logic [15:0] exp_d;
        logic [AW-1:0] exp_pc;
        int gap, hold;
        bit last;
        i_start = 1'b1; i_count = cnt[AW-1:0];
        tick();
        i_start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1 || o_instr_valid !== 1'b0 || o_timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL start_fetch busy=%b iv=%b err=%b required busy=1 iv=0 err=0", o_busy, o_instr_valid, o_timeout_err);
        end
        tick();
        for (int i = 0; i < cnt; i++) begin
            exp_d  = m_mem[i];
            exp_pc = i[AW-1:0];
            last   = (i == cnt - 1);
            n_cmp++;
            if (o_instr_valid !== 1'b1 || o_dout !== exp_d || o_pc !== exp_pc) begin
                n_err++;
                $display("FAIL present i=%0d dout=%h pc=%0d iv=%b required dout=%h pc=%0d iv=1", i, o_dout, o_pc, o_instr_valid, exp_d, exp_pc);
            end
            if (poke && i == 0) begin
                i_load_en = 1'b1; i_load_addr = 8'd1; i_load_data = 16'hFFFF;
                i_start = 1'b1; i_count = 8'd1;
                tick();
                i_load_en = 1'b0; i_start = 1'b0;
                n_cmp++;
                if (o_instr_valid !== 1'b1 || o_pc !== exp_pc || o_dout !== exp_d || o_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_ignore pc=%0d dout=%h iv=%b required pc=%0d dout=%h iv=1", o_pc, o_dout, o_instr_valid, exp_pc, exp_d);
                end
            end
            gap = $urandom_range(1, 4);
            repeat (gap) begin
                tick();
                n_cmp++;
                if (o_dout !== exp_d || o_instr_valid !== 1'b1 || o_pc !== exp_pc) begin
                    n_err++;
                    $display("FAIL hold_stable i=%0d dout=%h iv=%b required dout=%h iv=1", i, o_dout, o_instr_valid, exp_d);
                end
            end
            hold = $urandom_range(hold_min, hold_max);
            i_done = 1'b1;
            tick();
            n_cmp++;
            if (last) begin
                if (o_finished !== 1'b1 || o_busy !== 1'b0 || o_pc !== exp_pc) begin
                    n_err++;
                    $display("FAIL finish_pulse fin=%b busy=%b pc=%0d required fin=1 busy=0 pc=%0d", o_finished, o_busy, o_pc, exp_pc);
                end
            end else begin
                if (o_instr_valid !== 1'b0 || o_busy !== 1'b1 || o_pc !== exp_pc + 1'b1) begin
                    n_err++;
                    $display("FAIL advance iv=%b busy=%b pc=%0d required iv=0 busy=1 pc=%0d", o_instr_valid, o_busy, o_pc, i + 1);
                end
            end
            for (int h = 1; h < hold; h++) begin
                tick();
                n_cmp++;
                if (last) begin
                    if (o_finished !== 1'b0 || o_busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL level_once_last fin=%b busy=%b required fin=0 busy=0", o_finished, o_busy);
                    end
                end else if (o_pc !== exp_pc + 1'b1) begin
                    n_err++;
                    $display("FAIL level_once pc=%0d required %0d", o_pc, i + 1);
                end
            end
            i_done = 1'b0;
            if (!last && hold == 1) tick();
        end
        tick();
        n_cmp++;
        if (o_finished !== 1'b0 || o_busy !== 1'b0 || o_instr_valid !== 1'b0 ||
            o_pc !== exp_pc || o_dout !== exp_d) begin
            n_err++;
            $display("FAIL idle_after fin=%b busy=%b iv=%b pc=%0d dout=%h required fin=0 busy=0 iv=0 pc=%0d dout=%h",
                     o_finished, o_busy, o_instr_valid, o_pc, o_dout, exp_pc, exp_d);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (o_dout !== 16'h0 || o_pc !== '0 || o_instr_valid !== 1'b0 || o_busy !== 1'b0 ||
            o_finished !== 1'b0 || o_timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state dout=%h pc=%0d iv=%b busy=%b fin=%b err=%b required all zero",
                     o_dout, o_pc, o_instr_valid, o_busy, o_finished, o_timeout_err);
        end
        #20;
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_word(0, 16'h1234);
        load_word(1, 16'h5678);
        load_word(2, 16'h9ABC);
        load_word(3, 16'h0F0F);
        run_prog(3, 1, 1, 1'b0);
    endtask

    task automatic test_level_hold();
        run_prog(3, 5, 5, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_prog(3, 1, 3, 1'b1);
    endtask

    task automatic test_count_zero();
        i_start = 1'b1; i_count = '0;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (o_busy !== 1'b0 || o_finished !== 1'b0 || o_instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL count_zero k=%0d busy=%b fin=%b iv=%b required 0 0 0", k, o_busy, o_finished, o_instr_valid);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        i_start = 1'b1; i_count = 8'd2;
        tick();
        i_start = 1'b0;
        tick();
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (o_timeout_err !== 1'b0 || o_instr_valid !== 1'b1) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_err++;
            $display("FAIL timeout_early err=%b iv=%b required err=0 iv=1 for %0d WAIT cycles", o_timeout_err, o_instr_valid, TIMEOUT - 1);
        end
        tick();
        n_cmp++;
        if (o_timeout_err !== 1'b1 || o_busy !== 1'b0 || o_instr_valid !== 1'b0 ||
            o_dout !== 16'h1234 || o_pc !== '0) begin
            n_err++;
            $display("FAIL timeout_err err=%b busy=%b iv=%b dout=%h pc=%0d required err=1 busy=0 iv=0 dout=1234 pc=0",
                     o_timeout_err, o_busy, o_instr_valid, o_dout, o_pc);
        end
        load_word(3, 16'hBEEF);
        n_cmp++;
        if (o_timeout_err !== 1'b1 || o_dout !== 16'h1234) begin
            n_err++;
            $display("FAIL error_sticky err=%b dout=%h required err=1 dout=1234", o_timeout_err, o_dout);
        end
        run_prog(4, 1, 2, 1'b0);
    endtask

    task automatic test_async_reset();
        i_start = 1'b1; i_count = 8'd3;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        #3;
        i_reset = 1'b0;
        #1;
        n_cmp++;
        if (o_dout !== 16'h0 || o_pc !== '0 || o_instr_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset dout=%h pc=%0d iv=%b busy=%b required 0 0 0 0", o_dout, o_pc, o_instr_valid, o_busy);
        end
        #12;
        i_reset = 1'b1;
        tick();
        run_prog(3, 1, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int a = 0; a < DEPTH; a++) load_word(a, 16'($urandom));
        run_prog(DEPTH - 1, 1, 1, 1'b0);
        for (int r = 0; r < 6; r++) run_prog($urandom_range(1, 20), 1, 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_hold();
        test_busy_ignore();
        test_count_zero();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
